// File: rtl/seg_disp_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared types and constants for the seven-segment display arbiter.
//   DISP_W       : width of one display word (8 hex digits)
//   OWNER_W      : width of a requester index (up to 8 requesters)
//   disp_state_e : arbiter states; BLANK is only reachable when the design is
//                  built with SEG_DISP_ARB_BLANK_GAP_EN defined
// -----------------------------------------------------------------------------
package seg_disp_pkg;

  localparam int DISP_W  = 32;
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2
  } disp_state_e;

endpackage : seg_disp_pkg

// File: rtl/seg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// seg_rr_arbiter
// Purely combinational round-robin picker. The search starts at ptr_i+1 and
// wraps modulo NUM_REQ, so the requester granted last has lowest priority.
// Ports:
//   req_i       in  NUM_REQ  request vector
//   ptr_i       in  OWNER_W  index of the previous winner
//   grant_o     out NUM_REQ  one-hot winner (all zero when nothing requests)
//   grant_idx_o out OWNER_W  winner index (0 when nothing requests)
//   any_valid_o out 1        at least one request is present
// -----------------------------------------------------------------------------
import seg_disp_pkg::*;

module seg_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [OWNER_W-1:0] grant_idx_o,
  output logic               any_valid_o
);

  logic [NUM_REQ-1:0] cand_mask;

  // Walk the candidates from farthest (ptr+NUM_REQ, i.e. ptr itself) down to
  // nearest (ptr+1); the last hit overwrites earlier ones, so the nearest
  // valid requester after the pointer wins. Masks avoid variable bit-selects.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    cand_mask   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_mask = NUM_REQ'(1) << ((int'(ptr_i) + k) % NUM_REQ);
      if ((req_i & cand_mask) != '0) begin
        grant_o     = cand_mask;
        grant_idx_o = OWNER_W'((int'(ptr_i) + k) % NUM_REQ);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule : seg_rr_arbiter

// File: rtl/seg_disp_arbiter.sv
// -----------------------------------------------------------------------------
// seg_disp_arbiter
// Shares one 8-digit seven-segment display between NUM_REQ requesters. Each
// requester offers a 32-bit word with valid/ready; grants are round-robin and a
// granted word stays on the display for at least HOLD_CYCLES cycles.
//
// Optional build macro: SEG_DISP_ARB_BLANK_GAP_EN
//   When defined, a hand-over to a different owner at the end of a hold first
//   blanks the display for BLANK_CYCLES cycles (disp_blank=1), then grants the
//   round-robin winner re-evaluated at the end of the gap. When undefined,
//   BLANK is unreachable and disp_blank is constant 0.
//
// Ports:
//   clk        in  1               system clock
//   reset      in  1               synchronous active-high reset
//   req_valid  in  NUM_REQ         requester i offers a word
//   req_data   in  32*NUM_REQ      requester i word in bits [32i+31:32i]
//   req_ready  out NUM_REQ         one-cycle one-hot accept pulse
//   disp_data  out 32              word to the seven-segment scan driver
//   disp_owner out 3               index of the last granted requester
//   disp_busy  out 1               high in HOLD and BLANK
//   disp_blank out 1               scan driver blanks all digits while high
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
import seg_disp_pkg::*;

module seg_disp_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_CYCLES  = 1024,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DISP_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DISP_W-1:0]         disp_data,
  output logic [OWNER_W-1:0]        disp_owner,
  output logic                      disp_busy,
  output logic                      disp_blank
);

  // One down-counter serves both the hold time and the blank gap.
  localparam int CNT_MAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  disp_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DISP_W-1:0]    data_q, data_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 busy_q, busy_d;
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
  logic                 blank_q, blank_d;
`endif

  logic [NUM_REQ-1:0]   win_oh;
  logic [OWNER_W-1:0]   win_idx;
  logic                 win_any;
  logic [DISP_W-1:0]    win_data;
  logic                 grant_now;

  seg_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (win_oh),
    .grant_idx_o (win_idx),
    .any_valid_o (win_any)
  );

  // Word offered by the current round-robin winner.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == OWNER_W'(k)) begin
        win_data = DISP_W'(req_data >> (k * DISP_W));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    ready_d   = '0;           // ready is a single-cycle pulse
    grant_now = 1'b0;
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
    blank_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (win_any) begin
          grant_now = 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (win_any) begin
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
          // Only an owner change pays for the blank gap.
          if (win_idx != owner_q) begin
            state_d = BLANK;
            cnt_d   = CNT_W'(BLANK_CYCLES - 1);
            blank_d = 1'b1;
          end else begin
            grant_now = 1'b1;
          end
`else
          grant_now = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      BLANK: begin
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          blank_d = 1'b1;
        end else if (win_any) begin
          // Winner re-evaluated here; the original candidate may have left.
          grant_now = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_now) begin
      state_d = HOLD;
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      data_d  = win_data;
      owner_d = win_idx;
      ptr_d   = win_idx;
      ready_d = win_oh;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= OWNER_W'(NUM_REQ - 1);  // requester 0 first after reset
      ready_q <= '0;
      busy_q  <= 1'b0;
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign disp_data  = data_q;
  assign disp_owner = owner_q;
  assign disp_busy  = busy_q;
`ifdef SEG_DISP_ARB_BLANK_GAP_EN
  assign disp_blank = blank_q;
`else
  assign disp_blank = 1'b0;
`endif

endmodule : seg_disp_arbiter

// File: tb/tb_seg_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_disp_arbiter
// Directed self-checking bench for seg_disp_arbiter with default parameters
// (4 requesters, 1024-cycle hold, 64-cycle blank gap). Inputs change #1 after
// the rising edge; outputs are sampled at the same point, so each observation
// reflects the edge just taken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seg_disp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 1024;
  localparam int BLANK   = 64;

`ifdef SEG_DISP_ARB_BLANK_GAP_EN
  localparam int EXP_BLANK = BLANK;
`else
  localparam int EXP_BLANK = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  disp_data;
  logic [2:0]   disp_owner;
  logic         disp_busy;
  logic         disp_blank;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  seg_disp_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_CYCLES  (HOLD),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .disp_data  (disp_data),
    .disp_owner (disp_owner),
    .disp_busy  (disp_busy),
    .disp_blank (disp_blank)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until a ready pulse appears or the budget runs out.
  task automatic wait_ready(output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (req_ready === 4'b0000 && waited < 3000);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (disp_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", disp_data, 32'h0); end
    checks++; if (disp_owner !== 3'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", disp_owner); end
    checks++; if (disp_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", disp_busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (disp_blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", disp_blank); end
    $display("reset: data=%h owner=%0d busy=%b", disp_data, disp_owner, disp_busy);
  endtask

  task automatic test_single_grant();
    int busy_cnt;
    int extra_ready;
    do_reset();
    req_data[31:0] = 32'h1234_5678;
    req_valid      = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    checks++; if (disp_data !== 32'h1234_5678) begin failures++; $display("FAIL single_data got=%h exp=12345678", disp_data); end
    checks++; if (disp_owner !== 3'd0) begin failures++; $display("FAIL single_owner got=%0d exp=0", disp_owner); end
    checks++; if (disp_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", disp_busy); end
    $display("grant: req=0 data=%h cycle=%0d", disp_data, cycle);
    req_valid   = 4'b0000;
    busy_cnt    = 1;
    extra_ready = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (disp_busy === 1'b1) busy_cnt++;
      if (req_ready !== 4'b0000) extra_ready++;
    end
    checks++; if (busy_cnt !== HOLD) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, HOLD); end
    checks++; if (extra_ready !== 0) begin failures++; $display("FAIL single_extra_ready got=%0d exp=0", extra_ready); end
    checks++; if (disp_data !== 32'h1234_5678) begin failures++; $display("FAIL idle_keeps_data got=%h exp=12345678", disp_data); end
    checks++; if (disp_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", disp_busy); end
  endtask

  // All four valid: 0,1,2,3 in turn; then 0 and 2 re-request and the pointer
  // wraps so 0 wins.
  task automatic test_round_robin();
    logic [31:0] exp_word [5];
    int          exp_idx  [5];
    int          waited;
    int          last;
    logic [3:0]  exp_oh;
    exp_word = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0010};
    exp_idx  = '{0, 1, 2, 3, 0};
    do_reset();
    req_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    req_valid = 4'b1111;
    last      = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(waited);
      exp_oh = 4'b0001 << exp_idx[g];
      checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", g, req_ready, exp_oh); end
      checks++; if (disp_data !== exp_word[g]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", g, disp_data, exp_word[g]); end
      checks++; if (disp_owner !== 3'(exp_idx[g])) begin failures++; $display("FAIL rr_owner[%0d] got=%0d exp=%0d", g, disp_owner, exp_idx[g]); end
      if (g > 0) begin
        checks++; if (cycle - last !== HOLD) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", g, cycle - last, HOLD); end
      end
      $display("grant: req=%0d data=%h cycle=%0d", disp_owner, disp_data, cycle);
      last = cycle;
      req_valid = req_valid & ~exp_oh;
      if (g == 3) begin
        req_data[31:0]  = 32'hA000_0010;
        req_data[95:64] = 32'hA000_0012;
        req_valid       = 4'b0101;
      end
      tick();
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_pulse_len[%0d] got=%b exp=0000", g, req_ready); end
    end
  endtask

  task automatic test_continuous();
    int          waited;
    int          last;
    logic [31:0] exp_word;
    do_reset();
    req_data[95:64] = 32'h2000_0000;
    req_valid       = 4'b0100;
    last            = 0;
    for (int n = 0; n < 3; n++) begin
      exp_word = 32'h2000_0000 + 32'(n);
      wait_ready(waited);
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL cont_ready[%0d] got=%b exp=0100", n, req_ready); end
      checks++; if (disp_data !== exp_word) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", n, disp_data, exp_word); end
      if (n > 0) begin
        checks++; if (cycle - last !== HOLD) begin failures++; $display("FAIL cont_spacing[%0d] got=%0d exp=%0d", n, cycle - last, HOLD); end
      end
      $display("grant: req=2 data=%h cycle=%0d", disp_data, cycle);
      last = cycle;
      req_data[95:64] = 32'h2000_0000 + 32'(n + 1);
    end
  endtask

  task automatic test_drop();
    int bad_ready;
    int bad_data;
    int bad_blank;
    do_reset();
    req_data[31:0]  = 32'h0D0D_0000;
    req_data[63:32] = 32'h1111_1111;
    req_data[95:64] = 32'h2222_2222;
    req_valid       = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL drop_first_ready got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    bad_ready = 0;
    bad_data  = 0;
    bad_blank = 0;
    for (int i = 0; i < 1100; i++) begin
      if (i == 10)  req_valid = 4'b0010;
      if (i == 110) req_valid = 4'b0000;
      tick();
      if (req_ready !== 4'b0000) bad_ready++;
      if (disp_data !== 32'h0D0D_0000) bad_data++;
      if (disp_blank !== 1'b0) bad_blank++;
    end
    checks++; if (bad_ready !== 0) begin failures++; $display("FAIL drop_ready got=%0d exp=0", bad_ready); end
    checks++; if (bad_data !== 0) begin failures++; $display("FAIL drop_data got=%0d exp=0", bad_data); end
    checks++; if (bad_blank !== 0) begin failures++; $display("FAIL drop_blank got=%0d exp=0", bad_blank); end
    checks++; if (disp_busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", disp_busy); end
    // Requester 1 must have left nothing behind: 2 wins straight away.
    req_valid = 4'b0100;
    tick();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL drop_no_stale got=%b exp=0100", req_ready); end
    checks++; if (disp_data !== 32'h2222_2222) begin failures++; $display("FAIL drop_next_data got=%h exp=22222222", disp_data); end
    $display("grant: req=%0d data=%h cycle=%0d", disp_owner, disp_data, cycle);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req_data[31:0] = 32'h5555_0000;
    req_valid      = 4'b0001;
    tick();
    req_valid = 4'b0000;
    repeat (523) tick();   // hold counter now reads 500
    checks++; if (disp_busy !== 1'b1) begin failures++; $display("FAIL midhold_busy got=%b exp=1", disp_busy); end
    reset            = 1'b1;
    req_data[127:96] = 32'h3333_3333;
    req_valid        = 4'b1001;
    tick();
    checks++; if (disp_data !== 32'h0) begin failures++; $display("FAIL midreset_data got=%h exp=0", disp_data); end
    checks++; if (disp_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", disp_busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL midreset_ready got=%b exp=0000", req_ready); end
    checks++; if (disp_owner !== 3'd0) begin failures++; $display("FAIL midreset_owner got=%0d exp=0", disp_owner); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL postreset_ready got=%b exp=0001", req_ready); end
    checks++; if (disp_data !== 32'h5555_0000) begin failures++; $display("FAIL postreset_data got=%h exp=55550000", disp_data); end
    $display("grant: req=%0d data=%h cycle=%0d", disp_owner, disp_data, cycle);
  endtask

  // Owner change 0 -> 1, then a same-owner re-grant of 1.
  task automatic test_blank_gap();
    int waited;
    int last;
    int blank_cnt;
    do_reset();
    req_data[31:0]  = 32'hB000_0000;
    req_data[63:32] = 32'hB000_0001;
    req_valid       = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL gap_first_ready got=%b exp=0001", req_ready); end
    last      = cycle;
    req_valid = 4'b0010;
    blank_cnt = 0;
    waited    = 0;
    do begin
      tick();
      waited++;
      if (disp_blank === 1'b1) blank_cnt++;
    end while (req_ready === 4'b0000 && waited < 3000);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL gap_ready got=%b exp=0010", req_ready); end
    checks++; if (blank_cnt !== EXP_BLANK) begin failures++; $display("FAIL gap_blank_len got=%0d exp=%0d", blank_cnt, EXP_BLANK); end
    checks++; if (cycle - last !== HOLD + EXP_BLANK) begin failures++; $display("FAIL gap_spacing got=%0d exp=%0d", cycle - last, HOLD + EXP_BLANK); end
    checks++; if (disp_blank !== 1'b0) begin failures++; $display("FAIL gap_blank_end got=%b exp=0", disp_blank); end
    checks++; if (disp_data !== 32'hB000_0001) begin failures++; $display("FAIL gap_data got=%h exp=b0000001", disp_data); end
    $display("grant: req=%0d data=%h cycle=%0d blank_cycles=%0d", disp_owner, disp_data, cycle, blank_cnt);
    last            = cycle;
    req_data[63:32] = 32'hB000_0002;
    blank_cnt       = 0;
    waited          = 0;
    do begin
      tick();
      waited++;
      if (disp_blank === 1'b1) blank_cnt++;
    end while (req_ready === 4'b0000 && waited < 3000);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL same_ready got=%b exp=0010", req_ready); end
    checks++; if (blank_cnt !== 0) begin failures++; $display("FAIL same_blank got=%0d exp=0", blank_cnt); end
    checks++; if (cycle - last !== HOLD) begin failures++; $display("FAIL same_spacing got=%0d exp=%0d", cycle - last, HOLD); end
    checks++; if (disp_data !== 32'hB000_0002) begin failures++; $display("FAIL same_data got=%h exp=b0000002", disp_data); end
    $display("grant: req=%0d data=%h cycle=%0d blank_cycles=%0d", disp_owner, disp_data, cycle, blank_cnt);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_continuous();
    test_drop();
    test_reset_mid_hold();
    test_blank_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg_disp_arbiter
